// File: rtl/softmax_argmax.sv
// rtl/softmax_argmax.sv - registered signed argmax over LAYER_SZ activations
// Optional max_value output enabled by defining SOFTMAX_MAX_OUT_EN.
module softmax_argmax #(
  parameter int SIZE     = 16,
  parameter int LAYER_SZ = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [0:LAYER_SZ-1][SIZE-1:0]  values,
  output logic [SIZE-1:0]                class_out,
  output logic                           out_valid
`ifdef SOFTMAX_MAX_OUT_EN
  ,
  output logic [SIZE-1:0]                max_value
`endif
);

  logic signed [SIZE-1:0] best_val;
  logic        [SIZE-1:0] best_idx;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_val = values[0];
    best_idx = '0;
    for (int i = 1; i < LAYER_SZ; i++) begin
      if ($signed(values[i]) > best_val) begin
        best_val = values[i];
        best_idx = SIZE'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        class_out <= best_idx;
      end
    end
  end

`ifdef SOFTMAX_MAX_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_value <= '0;
    end else if (in_valid) begin
      max_value <= best_val;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_argmax.sv
// tb/tb_softmax_argmax.sv - self-checking bench for softmax_argmax (LAYER_SZ 1, 2, 4)
// Checks max_value too when SOFTMAX_MAX_OUT_EN is defined.
module tb_softmax_argmax;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [0:0][15:0]  v1 = '0;
  logic [0:1][15:0]  v2 = '0;
  logic [0:3][15:0]  v4 = '0;
  logic [15:0]       cls1, cls2, cls4;
  logic              vld1, vld2, vld4;
  logic [15:0]       mx1, mx2, mx4;

  int total = 0;
  int bad   = 0;

  // expected state
  logic [15:0] e_cls1, e_cls2, e_cls4, e_mx1, e_mx2, e_mx4;
  logic        e_vld;

  always #5 clk = ~clk;

  softmax_argmax #(.SIZE(16), .LAYER_SZ(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .values(v1),
    .class_out(cls1), .out_valid(vld1)
`ifdef SOFTMAX_MAX_OUT_EN
    , .max_value(mx1)
`endif
  );
  softmax_argmax #(.SIZE(16), .LAYER_SZ(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .values(v2),
    .class_out(cls2), .out_valid(vld2)
`ifdef SOFTMAX_MAX_OUT_EN
    , .max_value(mx2)
`endif
  );
  softmax_argmax #(.SIZE(16), .LAYER_SZ(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .values(v4),
    .class_out(cls4), .out_valid(vld4)
`ifdef SOFTMAX_MAX_OUT_EN
    , .max_value(mx4)
`endif
  );

`ifndef SOFTMAX_MAX_OUT_EN
  assign mx1 = '0;
  assign mx2 = '0;
  assign mx4 = '0;
`endif

  // Reference: find the largest signed value, then the first index holding it.
  function automatic int ref_idx(input int q[$]);
    int m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    foreach (q[i]) if (q[i] == m) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic r);
    int q1[$], q2[$], q4[$];
    int k;
    in_valid = v;
    rst      = r;
    if (r) begin
      {e_cls1, e_cls2, e_cls4, e_mx1, e_mx2, e_mx4} = '0;
      e_vld = 1'b0;
    end else begin
      e_vld = v;
      if (v) begin
        q1.push_back(int'($signed(v1[0])));
        for (int i = 0; i < 2; i++) q2.push_back(int'($signed(v2[i])));
        for (int i = 0; i < 4; i++) q4.push_back(int'($signed(v4[i])));
        k = ref_idx(q1); e_cls1 = 16'(k); e_mx1 = 16'(q1[k]);
        k = ref_idx(q2); e_cls2 = 16'(k); e_mx2 = 16'(q2[k]);
        k = ref_idx(q4); e_cls4 = 16'(k); e_mx4 = 16'(q4[k]);
      end
    end
    @(posedge clk);
    #1;
    chk("cls1", cls1, e_cls1);
    chk("cls2", cls2, e_cls2);
    chk("cls4", cls4, e_cls4);
    chk("vld1", {15'd0, vld1}, {15'd0, e_vld});
    chk("vld2", {15'd0, vld2}, {15'd0, e_vld});
    chk("vld4", {15'd0, vld4}, {15'd0, e_vld});
`ifdef SOFTMAX_MAX_OUT_EN
    chk("mx1", mx1, e_mx1);
    chk("mx2", mx2, e_mx2);
    chk("mx4", mx4, e_mx4);
`endif
  endtask

  function automatic logic [15:0] rval();
    logic [15:0] pool [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  task automatic randomize_inputs();
    v1[0] = rval();
    for (int i = 0; i < 2; i++) v2[i] = rval();
    for (int i = 0; i < 4; i++) v4[i] = rval();
  endtask

  initial begin
    // reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // simple max and tie case
    v1 = {16'h0123};
    v2 = {16'h0800, 16'h0900};
    v4 = {16'h0100, 16'h0300, 16'h0300, 16'hFF00};
    step(1'b1, 1'b0);
    chk("simple_max", cls2, 16'd1);
    chk("tie_low_idx", cls4, 16'd1);

    // signed compare and all-negative case
    v2 = {16'h7F00, 16'h8000};
    v4 = {16'hFFFF, 16'hFF00, 16'h8000, 16'hFFFE};
    step(1'b1, 1'b0);
    chk("signed_cmp", cls2, 16'd0);
    chk("all_neg", cls4, 16'd0);

    // hold with in_valid low while inputs change
    for (int i = 0; i < 5; i++) begin
      randomize_inputs();
      step(1'b0, 1'b0);
    end

    // back-to-back inputs
    for (int i = 0; i < 20; i++) begin
      randomize_inputs();
      step(1'b1, 1'b0);
    end

    // reset coincident with a valid input discards it
    v2 = {16'h0000, 16'h0900};
    v4 = {16'h0000, 16'h0000, 16'h0000, 16'h0900};
    step(1'b1, 1'b1);
    chk("rst_cls", cls4, 16'd0);

    v2 = {16'h0800, 16'h0900};
    step(1'b1, 1'b0);
    chk("post_rst", cls2, 16'd1);

    // random mix of valid, idle and occasional reset
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
